wb_trace_fifo: RTL

Commit-trace capture buffer that sits directly downstream of the CPU core's writeback debug ports. Every cycle the core reports a retired instruction, the block stamps it with a sequence number, stores the record in a DEPTH-entry FIFO, and drains it to the trace checker or host over a valid/ready handshake. The checker can therefore stall without losing lockstep. Overflow is detected, counted and flagged, never silent.

---
 rtl/wb_trace_fifo_if.sv | 36 +++
 rtl/wb_trace_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/wb_trace_fifo_if.sv
// rtl/wb_trace_fifo_if.sv - writeback debug capture and trace drain bundle
interface wb_trace_fifo_if #(
    parameter int AW = 4
);
    logic          debug_wb_have_inst;
    logic [31:0]   debug_wb_pc;
    logic          debug_wb_ena;
    logic [4:0]    debug_wb_reg;
    logic [31:0]   debug_wb_value;
    logic          clear;
    logic          trace_ready;
    logic          trace_valid;
    logic [15:0]   trace_seq;
    logic [31:0]   trace_pc;
    logic          trace_ena;
    logic [4:0]    trace_reg;
    logic [31:0]   trace_value;
    logic [AW:0]   count;
    logic          overflow;
    logic [15:0]   drop_cnt;
    logic [31:0]   retired_cnt;

    modport slave (
        input  debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg,
               debug_wb_value, clear, trace_ready,
        output trace_valid, trace_seq, trace_pc, trace_ena, trace_reg,
               trace_value, count, overflow, drop_cnt, retired_cnt
    );

    modport master (
        output debug_wb_have_inst, debug_wb_pc, debug_wb_ena, debug_wb_reg,
               debug_wb_value, clear, trace_ready,
        input  trace_valid, trace_seq, trace_pc, trace_ena, trace_reg,
               trace_value, count, overflow, drop_cnt, retired_cnt
    );
endinterface

// File: rtl/wb_trace_fifo.sv
// rtl/wb_trace_fifo.sv - sequence-stamped commit-trace FIFO with overflow accounting
module wb_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    wb_trace_fifo_if.slave  bus
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [15:0]   mem_seq   [DEPTH];
    logic [31:0]   mem_pc    [DEPTH];
    logic          mem_ena   [DEPTH];
    logic [4:0]    mem_reg   [DEPTH];
    logic [31:0]   mem_value [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;
    logic [15:0]   seq_q, seq_d;
    logic [31:0]   retired_q, retired_d;

    logic valid, full, push, pop, store, drop;

    assign valid = (count_q != '0);
    assign full  = (count_q == FULL_CNT);
    assign push  = bus.debug_wb_have_inst & ~bus.clear;
    assign pop   = valid & bus.trace_ready & ~bus.clear;
    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    assign store = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        seq_d      = seq_q;
        retired_d  = retired_q;
        if (bus.clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            seq_d      = '0;
            retired_d  = '0;
        end else begin
            if (store) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (store && !pop)      count_d = count_q + (AW+1)'(1);
            else if (pop && !store) count_d = count_q - (AW+1)'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
            end
            if (push) begin
                seq_d     = seq_q + 16'd1;
                retired_d = retired_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            seq_q      <= '0;
            retired_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            seq_q      <= seq_d;
            retired_q  <= retired_d;
        end
    end

    // Record storage is deliberately unreset; pointers and count alone define validity.
    always_ff @(posedge clk) begin
        if (store) begin
            mem_seq[wr_ptr_q]   <= seq_q;
            mem_pc[wr_ptr_q]    <= bus.debug_wb_pc;
            mem_ena[wr_ptr_q]   <= bus.debug_wb_ena;
            mem_reg[wr_ptr_q]   <= bus.debug_wb_ena ? bus.debug_wb_reg : 5'd0;
            mem_value[wr_ptr_q] <= bus.debug_wb_ena ? bus.debug_wb_value : 32'd0;
        end
    end

    assign bus.trace_valid = valid;
    assign bus.trace_seq   = valid ? mem_seq[rd_ptr_q]   : 16'd0;
    assign bus.trace_pc    = valid ? mem_pc[rd_ptr_q]    : 32'd0;
    assign bus.trace_ena   = valid ? mem_ena[rd_ptr_q]   : 1'b0;
    assign bus.trace_reg   = valid ? mem_reg[rd_ptr_q]   : 5'd0;
    assign bus.trace_value = valid ? mem_value[rd_ptr_q] : 32'd0;
    assign bus.count       = count_q;
    assign bus.overflow    = overflow_q;
    assign bus.drop_cnt    = drop_q;
    assign bus.retired_cnt = retired_q;
endmodule
